uart_tx_readback: RTL and testbench
===================================

// Module: uart_tx_readback
// PURPOSE
// - UART transmitter, the PC-bound counterpart of the configuration receiver. Sends two kinds of frames.
// - Dump frames: reads the pulse/delay configuration bytes back out of the config RAM and sends them, so the PC can verify what was written.
// - End-of-sequence frames: a status byte sent when the last delay stage raises its end flag.
// - Runs on the raw board clock, same domain as the receiver and the RAM.
// PARAMETERS
// - CLK_HZ       50_000_000  frequency of clk_Tx.
// - BAUD         9600        line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated; must be >= 4.
// - ADDR_W       8           RAM address width.
// - STOP_BITS    1           1 or 2 stop bits.
// - BIT_REVERSE  1           1: reverse the RAM byte {b0..b7} before sending, so echoed bytes match the PC's originals.
// - END_CODE     8'hA5       status byte sent on end_evt.
// PORTS
// - clk_Tx    in   1       Board clock.
// - rst       in   1       Asynchronous, active-high reset.
// - dump_req  in   1       1-cycle pulse: dump RAM[0..dump_len-1].
// - dump_len  in   ADDR_W  Byte count. Sampled on dump_req. 0 = no-op.
// - end_evt   in   1       1-cycle pulse: send END_CODE.
// - rd_addr   out  ADDR_W  RAM read address.
// - rd_data   in   8       RAM read data, valid one cycle after rd_addr changes.
// - Tx        out  1       Serial line, idle high.
// - busy      out  1       High from request acceptance until the last stop bit ends.
// - done      out  1       1-cycle pulse after the final stop bit of a dump or status frame.
// BEHAVIOUR
// - Reset values: Tx=1, busy=0, done=0, rd_addr=0, FSM=IDLE, end_pend=0, baud counter=0.
// - Frame format: 1 start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT cycles.
// - FSM states: IDLE -> FETCH -> LOAD -> START -> DATA -> STOP -> NEXT.
//   - IDLE: on dump_req with dump_len != 0: latch the length, rd_addr=0, busy=1, go to FETCH.
//     Otherwise, on end_pend: load END_CODE, go to START, skipping FETCH/LOAD.
//   - FETCH: wait 1 cycle for RAM latency.
//   - LOAD: shift register <= rd_data, bit-reversed if BIT_REVERSE.
//   - START, DATA (8 bits, bit index 0..7), STOP (STOP_BITS bits).
//   - NEXT (dump): if rd_addr == len-1, finish. Otherwise increment rd_addr and go to FETCH.
//     The gap between frames is 2 cycles of idle-high; this is legal UART.
//   - Finish: pulse done, busy=0, go to IDLE.
// - Latency: Tx falls 3 cycles after the dump_req cycle (IDLE, FETCH, LOAD), or 1 cycle after IDLE for a status frame.
// - end_evt sets end_pend, at any time including mid-dump. end_pend clears when END_CODE is loaded.
//   Multiple end_evt while pending collapse into one frame.
// - dump_req and end_evt in the same cycle: the dump runs first; the status frame follows immediately after it, with no return to idle-wait.
// - dump_req while busy: ignored. No queueing.
// - dump_len = 0: ignored; busy stays 0 and no done pulse.
// - dump_len = 2^ADDR_W-1: addresses 0..254. Counter compare is exact, no wrap.
// - The baud counter restarts at every bit boundary; there is no drift accumulation.
// - rst mid-frame: Tx returns to 1 immediately (async). The partial frame is abandoned. end_pend is cleared.
// STRUCTURE
// - Shared package: CLKS_PER_BIT computation, FSM state encoding, END_CODE default.
//   The receiver uses the same baud constant from this package.
// - One sub-module: uart_baud_tick. A counter with a restart input; it emits a tick at the end of each bit period and at mid-bit.
// - Everything else (FSM, byte counter, shift register, end_pend) sits in this file.
// - Top-level wiring: rd_addr/rd_data use a second read port on the config RAM; end_evt is driven from the end-flag stretcher output.
// TESTING
// - All tests use CLK_HZ=160, BAUD=10 (16 clk/bit).
// - Reset: hold rst -> Tx=1, busy=0, rd_addr=0. Assert rst mid-DATA -> Tx=1 in the same cycle; no done pulse.
// - Single dump: RAM[0]=8'h01, dump_len=1, BIT_REVERSE=1 -> line carries 8'h80.
//   Tx bits: 0, then 0000 0001, then 1. Each bit 16 cycles. done 160 cycles after the start bit begins.
// - Multi-byte dump: RAM={8'h12,8'h34,8'hFF}, dump_len=3 -> decoder receives 48,2C,FF.
//   rd_addr sequence 0,1,2; busy continuous; exactly one done.
// - Collision: dump_req(len=1) and end_evt in the same cycle -> frames RAM[0] then A5, with a single busy window.
// - end_evt x3 during a dump -> exactly one A5 after the dump.
// - dump_req with dump_len=0 -> Tx stays 1, busy stays 0 for 200 cycles.
// - dump_req while busy -> ignored; the byte count equals the first request only.

Source files
------------

// File: rtl/uart_tx_readback_pkg.sv
// Shared constants for the configuration UART pair: baud divisor, transmitter FSM encoding,
// default end-of-sequence status byte and the byte-reversal helper.
package uart_tx_readback_pkg;

    localparam logic [7:0] END_CODE_DEFAULT = 8'hA5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;
    localparam logic [2:0] ST_NEXT  = 3'd6;

    // Integer-truncated divisor; the receiver derives its bit timing from the same function.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter with restart: pulses at the last cycle of each bit and at mid-bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick_end,
    output logic o_tick_mid
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick_end = !i_restart && (r_cnt == CNT_LAST);
    assign o_tick_mid = !i_restart && (r_cnt == CNT_MID);

endmodule

// File: rtl/uart_tx_readback.sv
// PC-bound UART transmitter: dumps config RAM bytes back to the host and sends a status
// byte when the last delay stage signals end of sequence.
module uart_tx_readback
    import uart_tx_readback_pkg::*;
#(
    parameter int         CLK_HZ      = 50_000_000,
    parameter int         BAUD        = 9600,
    parameter int         ADDR_W      = 8,
    parameter int         STOP_BITS   = 1,
    parameter int         BIT_REVERSE = 1,
    parameter logic [7:0] END_CODE    = END_CODE_DEFAULT
) (
    input  logic              clk_Tx,
    input  logic              rst,
    input  logic              dump_req,
    input  logic [ADDR_W-1:0] dump_len,
    input  logic              end_evt,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              Tx,
    output logic              busy,
    output logic              done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    logic [2:0]        r_state;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_len;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_idx;
    logic              r_stop_idx;
    logic              r_is_dump;
    logic              r_end_pend;

    logic w_in_bit;
    logic w_tick_end;
    logic w_unused_tick_mid;
    logic w_more_bytes;

    // Counter is held at zero outside the bit states so every frame starts on a fresh period.
    assign w_in_bit = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (clk_Tx),
        .i_rst      (rst),
        .i_restart  (!w_in_bit),
        .o_tick_end (w_tick_end),
        .o_tick_mid (w_unused_tick_mid)
    );

    assign w_more_bytes = r_is_dump && (r_rd_addr != (r_len - ADDR_ONE));

    always_ff @(posedge clk_Tx or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_addr  <= '0;
            r_len      <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_is_dump  <= 1'b0;
            r_end_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dump_req && (dump_len != '0)) begin
                        r_len     <= dump_len;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                        r_is_dump <= 1'b1;
                        r_state   <= ST_FETCH;
                    end else if (r_end_pend) begin
                        r_shift    <= END_CODE;
                        r_end_pend <= 1'b0;
                        r_busy     <= 1'b1;
                        r_is_dump  <= 1'b0;
                        r_tx       <= 1'b0;
                        r_state    <= ST_START;
                    end
                end
                ST_FETCH: r_state <= ST_LOAD;
                ST_LOAD: begin
                    r_shift <= (BIT_REVERSE != 0) ? bit_rev8(rd_data) : rd_data;
                    r_tx    <= 1'b0;
                    r_state <= ST_START;
                end
                ST_START: begin
                    if (w_tick_end) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= ST_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                // The next-byte decision is taken as the last stop bit ends, so NEXT doubles
                // as the RAM fetch cycle and a pending status frame starts with no idle gap.
                ST_STOP: begin
                    if (w_tick_end) begin
                        if (r_stop_idx != LAST_STOP) begin
                            r_stop_idx <= 1'b1;
                        end else if (w_more_bytes) begin
                            r_rd_addr <= r_rd_addr + ADDR_ONE;
                            r_state   <= ST_NEXT;
                        end else if (r_end_pend) begin
                            r_shift    <= END_CODE;
                            r_end_pend <= 1'b0;
                            r_is_dump  <= 1'b0;
                            r_tx       <= 1'b0;
                            r_state    <= ST_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_NEXT: r_state <= ST_LOAD;
                default: r_state <= ST_IDLE;
            endcase
            // A new event in the same cycle the code is loaded still earns its own frame.
            if (end_evt) begin
                r_end_pend <= 1'b1;
            end
        end
    end

    assign rd_addr = r_rd_addr;
    assign Tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_uart_tx_readback.sv
// Directed bench for uart_tx_readback at 16 clocks per bit: a line decoder pops expected
// bytes from a queue, side monitors count done pulses and busy windows.
module tb_uart_tx_readback;

    localparam int CLK_HZ = 160;
    localparam int BAUD   = 10;
    localparam int CPB    = 16;
    localparam int ADDR_W = 8;

    logic              clk_Tx   = 1'b0;
    logic              rst      = 1'b1;
    logic              dump_req = 1'b0;
    logic [ADDR_W-1:0] dump_len = '0;
    logic              end_evt  = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              Tx;
    logic              busy;
    logic              done;

    logic [7:0]        ram [0:255];
    logic [7:0]        exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int last_start  = 0;
    int n_frames    = 0;
    int n_done      = 0;
    int n_busy_rise = 0;
    int rst_cnt     = 0;

    uart_tx_readback #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .ADDR_W      (ADDR_W),
        .STOP_BITS   (1),
        .BIT_REVERSE (1),
        .END_CODE    (8'hA5)
    ) dut (
        .clk_Tx   (clk_Tx),
        .rst      (rst),
        .dump_req (dump_req),
        .dump_len (dump_len),
        .end_evt  (end_evt),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .Tx       (Tx),
        .busy     (busy),
        .done     (done)
    );

    // ---------------- clock / RAM / reset bookkeeping ----------------
    always #5 clk_Tx = ~clk_Tx;

    always @(posedge clk_Tx) begin
        cyc     <= cyc + 1;
        rd_data <= ram[rd_addr];
    end

    always @(posedge rst) rst_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- scoreboard: line decoder ----------------
    initial begin : decoder
        logic [7:0] b;
        logic       st_bit;
        logic       sp_bit;
        int         r0;
        forever begin
            @(negedge clk_Tx);
            if (!rst && Tx === 1'b0) begin
                r0 = rst_cnt;
                last_start = cyc;
                addr_q.push_back(rd_addr);
                repeat (CPB/2) @(negedge clk_Tx);
                st_bit = Tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_Tx);
                    b[i] = Tx;
                end
                repeat (CPB) @(negedge clk_Tx);
                sp_bit = Tx;
                if (rst_cnt == r0) begin
                    n_frames++;
                    check("start_bit", st_bit, 1'b0);
                    check("stop_bit", sp_bit, 1'b1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL frame_unexpected: got %02h expected no frame", b);
                    end else begin
                        check("frame_byte", b, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- done / busy monitor ----------------
    initial begin : side_monitor
        logic busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk_Tx);
            if (done === 1'b1) begin
                n_done++;
                check("done_timing", cyc - last_start, 160);
            end
            if (busy === 1'b1 && busy_prev !== 1'b1) n_busy_rise++;
            busy_prev = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_dump(input logic [7:0] len, input logic with_end);
        @(negedge clk_Tx);
        dump_req = 1'b1;
        dump_len = len;
        end_evt  = with_end;
        @(negedge clk_Tx);
        dump_req = 1'b0;
        dump_len = '0;
        end_evt  = 1'b0;
    endtask

    task automatic pulse_end();
        @(negedge clk_Tx);
        end_evt = 1'b1;
        @(negedge clk_Tx);
        end_evt = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk_Tx);
            n++;
        end
        check(name, busy, 1'b0);
        repeat (5) @(negedge clk_Tx);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int d0, b0, f0;
        logic tx_moved, busy_seen, done_seen;

        for (int i = 0; i < 256; i++) ram[i] = 8'h00;

        // Reset held
        repeat (5) @(negedge clk_Tx);
        check("reset_tx", Tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_rd_addr", rd_addr, 8'h00);
        check("reset_done", done, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk_Tx);

        // Single dump: 01 reversed -> 80, start bit three cycles after request
        ram[0] = 8'h01;
        exp_q.push_back(8'h80);
        d0 = n_done;
        @(negedge clk_Tx);
        dump_req = 1'b1;
        dump_len = 8'd1;
        @(negedge clk_Tx);
        dump_req = 1'b0;
        dump_len = '0;
        check("busy_accept", busy, 1'b1);
        check("tx_fetch", Tx, 1'b1);
        @(negedge clk_Tx);
        check("tx_load", Tx, 1'b1);
        @(negedge clk_Tx);
        check("tx_start_latency", Tx, 1'b0);
        wait_idle("single_idle");
        check("single_done_count", n_done - d0, 1);

        // Multi-byte dump
        ram[0] = 8'h12; ram[1] = 8'h34; ram[2] = 8'hFF;
        exp_q.push_back(8'h48); exp_q.push_back(8'h2C); exp_q.push_back(8'hFF);
        addr_q.delete();
        d0 = n_done; b0 = n_busy_rise; f0 = n_frames;
        pulse_dump(8'd3, 1'b0);
        wait_idle("multi_idle");
        check("multi_done_count", n_done - d0, 1);
        check("multi_busy_windows", n_busy_rise - b0, 1);
        check("multi_frames", n_frames - f0, 3);
        check("multi_addr_count", addr_q.size(), 3);
        for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
            check("multi_rd_addr", addr_q[i], i);
        end

        // Dump request and end event in the same cycle
        ram[0] = 8'h01;
        exp_q.push_back(8'h80); exp_q.push_back(8'hA5);
        b0 = n_busy_rise; f0 = n_frames;
        pulse_dump(8'd1, 1'b1);
        wait_idle("collide_idle");
        check("collide_busy_windows", n_busy_rise - b0, 1);
        check("collide_frames", n_frames - f0, 2);

        // Three end events during a dump collapse to one status frame
        ram[0] = 8'h12;
        exp_q.push_back(8'h48); exp_q.push_back(8'h2C); exp_q.push_back(8'hFF);
        exp_q.push_back(8'hA5);
        b0 = n_busy_rise; f0 = n_frames;
        pulse_dump(8'd3, 1'b0);
        repeat (50) @(negedge clk_Tx);
        pulse_end();
        repeat (200) @(negedge clk_Tx);
        pulse_end();
        repeat (150) @(negedge clk_Tx);
        pulse_end();
        wait_idle("end3_idle");
        repeat (200) @(negedge clk_Tx);
        check("end3_frames", n_frames - f0, 4);
        check("end3_busy_windows", n_busy_rise - b0, 1);

        // Zero length is a no-op
        d0 = n_done;
        tx_moved = 1'b0; busy_seen = 1'b0;
        pulse_dump(8'd0, 1'b0);
        repeat (200) begin
            @(negedge clk_Tx);
            if (Tx !== 1'b1) tx_moved = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        check("zero_len_tx_idle", tx_moved, 1'b0);
        check("zero_len_busy", busy_seen, 1'b0);
        check("zero_len_done", n_done - d0, 0);

        // Request while busy is dropped
        ram[0] = 8'h01;
        exp_q.push_back(8'h80);
        d0 = n_done; b0 = n_busy_rise; f0 = n_frames;
        pulse_dump(8'd1, 1'b0);
        repeat (40) @(negedge clk_Tx);
        pulse_dump(8'd3, 1'b0);
        wait_idle("ignore_idle");
        repeat (200) @(negedge clk_Tx);
        check("ignore_frames", n_frames - f0, 1);
        check("ignore_done_count", n_done - d0, 1);
        check("ignore_busy_windows", n_busy_rise - b0, 1);

        // Reset mid-DATA with a status frame pending: frame abandoned, nothing follows
        d0 = n_done; f0 = n_frames;
        pulse_dump(8'd1, 1'b0);
        repeat (10) @(negedge clk_Tx);
        pulse_end();
        repeat (30) @(negedge clk_Tx);
        check("tx_data_before_rst", Tx, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_tx", Tx, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        repeat (3) @(negedge clk_Tx);
        rst = 1'b0;
        tx_moved = 1'b0; busy_seen = 1'b0; done_seen = 1'b0;
        repeat (300) begin
            @(negedge clk_Tx);
            if (Tx !== 1'b1) tx_moved = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
            if (done !== 1'b0) done_seen = 1'b1;
        end
        check("rst_no_status_tx", tx_moved, 1'b0);
        check("rst_no_busy", busy_seen, 1'b0);
        check("rst_no_done", done_seen, 1'b0);
        check("rst_frames", n_frames - f0, 0);
        check("rst_done_count", n_done - d0, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
